ram_lsu: RTL
============

Name: ram_lsu

Overview:
Load/store unit sitting directly upstream of the 1 KB data RAM. It accepts one CPU data request at a time: byte, halfword or word, load or store. It drives the RAM's chip-enable, read, write, address and write-data inputs. Sub-word stores are done by read-modify-write, since the RAM only writes full 32-bit words. Loads are returned lane-extracted and sign- or zero-extended.

Parameters:
RAM_ORIGIN, 32'h400, base byte address of RAM window
RAM_LENGTH, 32'h100, window size in bytes; valid range is ORIGIN <= addr < ORIGIN+LENGTH

Ports:
iRAM_CLK  in  1  clock, rising edge
iRAM_RST  in  1  reset, asynchronous, active-low
iREQ  in  1  request strobe, sampled only in IDLE
iWE  in  1  1=store, 0=load
iSIZE  in  2  00=byte, 01=half, 10=word, 11=reserved (error)
iSIGNED  in  1  load sign-extend enable
iADDR  in  32  byte address
iWDATA  in  32  store data, right-justified
oBUSY  out  1  high whenever state != IDLE
oDONE  out  1  one-cycle completion pulse
oERR  out  1  valid with oDONE; misaligned, out-of-range or reserved size
oRDATA  out  32  load result, valid from oDONE onward
oRAM_CE  out  1  RAM chip enable
oRAM_RD  out  1  RAM read enable
oRAM_WR  out  1  RAM write enable
oRAM_ADDR  out  32  word-aligned RAM address {addr[31:2],2'b00}
oRAM_DATA  out  32  RAM write data
iRAM_DATA  in  32  RAM read data (combinational from RAM)

Behaviour:
- Reset, async while iRAM_RST=0:
  - state IDLE; all outputs 0; captured request registers 0.
  - An in-flight access is abandoned. oRAM_WR drops immediately and no partial store completes.
- FSM states: IDLE, RD, RMW_RD, WR, DONE, ERR.
- IDLE, on iREQ=1:
  - Capture addr, size, we, signed and wdata.
  - Error if any of: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0; addr outside window. Error goes to ERR.
  - Otherwise: load goes to RD; word store to WR; byte/half store to RMW_RD.
- RD:
  - CE=1, RD=1, ADDR set.
  - At clock edge, latch extracted and extended iRAM_DATA into oRDATA.
  - Next state DONE.
- RMW_RD:
  - CE=1, RD=1.
  - At edge, latch merge = iRAM_DATA with target lane replaced by wdata[7:0] or wdata[15:0].
  - Next state WR.
- WR:
  - CE=1, WR=1, ADDR set; DATA = merge (sub-word) or wdata (word).
  - RAM commits at the edge ending this state. Next state DONE.
- DONE: oDONE=1, oERR=0; next state IDLE.
- ERR: oDONE=1, oERR=1; CE/RD/WR stay 0 throughout; oRDATA unchanged; next state IDLE.
- RAM-side outputs are decoded from the state register only (Moore, glitch-free). oRAM_DATA=0 and oRAM_ADDR=0 outside RD/RMW_RD/WR.
- Lanes, little-endian:
  - byte lane addr[1:0]: 0 gives [7:0], 3 gives [31:24].
  - half lane addr[1]: 0 gives [15:0], 1 gives [31:16].
- Load extension: iSIGNED=1 replicates the lane MSB; iSIGNED=0 zero-fills; word loads pass through.
- oRDATA updates only on successful loads. It holds across stores and errors.
- Latency, counting request edge as E0, oDONE high during the cycle after:
  - load: E1
  - word store: E1
  - sub-word store: E2
  - error: E0
- iREQ outside IDLE, including during DONE/ERR, is ignored and not queued. The master must wait for oBUSY=0.
- A store followed by a load to the same word returns the new data. The RAM commits before the next RD state is possible.

Test Plan:
- Word store 0xDEADBEEF @0x404, then word load @0x404 -> oDONE one cycle after each accept; oRDATA=0xDEADBEEF; oERR=0.
- Word 0x11223344 @0x408, byte store 0xA5 @0x409 -> RMW_RD then WR visible on RAM pins; oRAM_DATA=0x1122A544; signed byte load @0x409 gives 0xFFFFFFA5, unsigned gives 0x000000A5.
- Half store 0x8001 @0x40A over 0x1122A544 -> word 0x8001A544; signed half load @0x40A gives 0xFFFF8001.
- Half load @0x403, word load @0x406, word load @0x500, size=11 -> each returns oDONE=oERR=1 one cycle after accept; oRAM_CE never asserted; oRDATA unchanged.
- iREQ held high with a different address throughout a sub-word store -> exactly one access performed; second request taken only after oBUSY falls.
- Assert iRAM_RST low during WR state of a sub-word store -> all outputs 0 immediately; FSM in IDLE after release; target RAM word unchanged.

Source files
------------

// File: rtl/ram_lsu.sv
// Load/store unit in front of the 1 KB data RAM: one request at a time,
// sub-word stores by read-modify-write, loads lane-extracted and extended.
module ram_lsu #(
    parameter logic [31:0] RAM_ORIGIN = 32'h400,
    parameter logic [31:0] RAM_LENGTH = 32'h100
) (
    input  logic        iRAM_CLK,
    input  logic        iRAM_RST,
    input  logic        iREQ,
    input  logic        iWE,
    input  logic [1:0]  iSIZE,
    input  logic        iSIGNED,
    input  logic [31:0] iADDR,
    input  logic [31:0] iWDATA,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oERR,
    output logic [31:0] oRDATA,
    output logic        oRAM_CE,
    output logic        oRAM_RD,
    output logic        oRAM_WR,
    output logic [31:0] oRAM_ADDR,
    output logic [31:0] oRAM_DATA,
    input  logic [31:0] iRAM_DATA
);
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 33;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RMW_RD = 3'd2,
        S_WR     = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   addr_q, addr_d, wdata_q, wdata_d, merge_q, merge_d, rdata_q, rdata_d;
    logic [1:0]      size_q, size_d;
    logic            we_q, we_d, sgn_q, sgn_d;
    logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic            ce_q, ce_d, rd_q, rd_d, wr_q, wr_d;
    logic [DW-1:0]   ram_addr_q, ram_addr_d, ram_data_q, ram_data_d;

    logic            in_win_c, req_err_c;
    logic [4:0]      shamt_c;
    logic [DW-1:0]   lane_c, load_val_c, lane_mask_c, merged_c;

    // Request legality: alignment, reserved size and RAM window
    always_comb begin
        in_win_c  = ({1'b0, iADDR} >= AW'(RAM_ORIGIN)) &&
                    ({1'b0, iADDR} < (AW'(RAM_ORIGIN) + AW'(RAM_LENGTH)));
        req_err_c = (iSIZE == 2'b11) ||
                    ((iSIZE == 2'b01) && iADDR[0]) ||
                    ((iSIZE == 2'b10) && (iADDR[1:0] != 2'b00)) ||
                    !in_win_c;
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        shamt_c = {addr_q[1:0], 3'b000};
        lane_c  = iRAM_DATA >> shamt_c;
        case (size_q)
            2'b00:   load_val_c = {{24{sgn_q & lane_c[7]}}, lane_c[7:0]};
            2'b01:   load_val_c = {{16{sgn_q & lane_c[15]}}, lane_c[15:0]};
            default: load_val_c = iRAM_DATA;
        endcase
        lane_mask_c = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt_c;
        merged_c    = (iRAM_DATA & ~lane_mask_c) | ((wdata_q << shamt_c) & lane_mask_c);
    end

    // Next state, captured request and registered output decode
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        we_d    = we_q;
        sgn_d   = sgn_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (iREQ) begin
                    addr_d  = iADDR;
                    size_d  = iSIZE;
                    we_d    = iWE;
                    sgn_d   = iSIGNED;
                    wdata_d = iWDATA;
                    if (req_err_c)            state_d = S_ERR;
                    else if (!iWE)            state_d = S_RD;
                    else if (iSIZE == 2'b10)  state_d = S_WR;
                    else                      state_d = S_RMW_RD;
                end
            end
            S_RD: begin
                rdata_d = load_val_c;
                state_d = S_DONE;
            end
            S_RMW_RD: begin
                merge_d = merged_c;
                state_d = S_WR;
            end
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE) || (state_d == S_ERR);
        err_d      = (state_d == S_ERR);
        rd_d       = (state_d == S_RD) || (state_d == S_RMW_RD);
        wr_d       = (state_d == S_WR);
        ce_d       = rd_d || wr_d;
        ram_addr_d = ce_d ? {addr_d[31:2], 2'b00} : '0;
        ram_data_d = wr_d ? ((size_d == 2'b10) ? wdata_d : merge_d) : '0;
    end

    always_ff @(posedge iRAM_CLK or negedge iRAM_RST) begin
        if (!iRAM_RST) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            we_q       <= 1'b0;
            sgn_q      <= 1'b0;
            wdata_q    <= '0;
            merge_q    <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ce_q       <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            we_q       <= we_d;
            sgn_q      <= sgn_d;
            wdata_q    <= wdata_d;
            merge_q    <= merge_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ce_q       <= ce_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

    assign oBUSY     = busy_q;
    assign oDONE     = done_q;
    assign oERR      = err_q;
    assign oRDATA    = rdata_q;
    assign oRAM_CE   = ce_q;
    assign oRAM_RD   = rd_q;
    assign oRAM_WR   = wr_q;
    assign oRAM_ADDR = ram_addr_q;
    assign oRAM_DATA = ram_data_q;

    // we_q is held for debug visibility of the captured request
    logic unused_c;
    assign unused_c = we_q;
endmodule
